// File: rtl/uart_pkg.sv
// Shared UART package: default widths used by the receiver, the transmitter
// and their FIFOs, plus the FIFO occupancy-count width helper.
package uart_pkg;

  localparam int UART_DBITS             = 8;
  localparam int UART_RX_FIFO_ADDR_BITS = 4;

  // Occupancy runs 0..2**addr_bits inclusive, so it needs one bit more
  // than the pointers.
  function automatic int fifo_cnt_w(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Circular-queue control: write/read pointers, occupancy count and flags.
// Holds no data; the owner keeps the storage array and uses w_addr/r_addr.
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN adds a sticky overrun flag.
//
// Ports:
//   clk_100MHz   system clock (rising edge)
//   reset_n      asynchronous active-low reset
//   wr_en        write request
//   rd_en        read (pop) request
//   clr_overrun  clears overrun            (UART_RX_FIFO_OVERRUN_EN only)
//   w_addr       slot to write this cycle
//   r_addr       head slot
//   wr_accept    write is taken this cycle
//   empty, full  occupancy flags
//   count        stored words, 0..2**ADDR_BITS
//   overrun      sticky dropped-write flag  (UART_RX_FIFO_OVERRUN_EN only)
module fifo_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_BITS = UART_RX_FIFO_ADDR_BITS
) (
  input  logic                              clk_100MHz,
  input  logic                              reset_n,
  input  logic                              wr_en,
  input  logic                              rd_en,
`ifdef UART_RX_FIFO_OVERRUN_EN
  input  logic                              clr_overrun,
  output logic                              overrun,
`endif
  output logic [ADDR_BITS-1:0]              w_addr,
  output logic [ADDR_BITS-1:0]              r_addr,
  output logic                              wr_accept,
  output logic                              empty,
  output logic                              full,
  output logic [fifo_cnt_w(ADDR_BITS)-1:0]  count
);

  localparam int CW = fifo_cnt_w(ADDR_BITS);
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_BITS);

  logic [ADDR_BITS-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_BITS-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 rd_accept;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH);
  assign count  = count_q;
  assign w_addr = w_ptr_q;
  assign r_addr = r_ptr_q;

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    count_d   = count_q;
    // A pop while full frees the very slot being written, so no drop.
    wr_accept = wr_en && (!full || rd_en);
    rd_accept = rd_en && !empty;

    if (wr_accept) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_accept) r_ptr_d = r_ptr_q + 1'b1;

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Set has priority over clear when both occur in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun)             overrun_d = 1'b0;
    if (wr_en && full && !rd_en) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers each word strobed by the receiver's data_ready
// and presents the oldest word on a show-ahead read port.
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN adds overrun/clr_overrun.
//
// Ports:
//   clk_100MHz   system clock (rising edge)
//   reset_n      asynchronous active-low reset
//   wr_en        write strobe (receiver data_ready)
//   wr_data      word to store (receiver data_out)
//   rd_en        pop the head word
//   rd_data      head word, zero when empty
//   empty, full  occupancy flags
//   count        stored words, 0..2**ADDR_BITS
//   overrun      sticky dropped-word flag  (UART_RX_FIFO_OVERRUN_EN only)
//   clr_overrun  clears overrun            (UART_RX_FIFO_OVERRUN_EN only)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBITS     = UART_DBITS,
  parameter int ADDR_BITS = UART_RX_FIFO_ADDR_BITS
) (
  input  logic                              clk_100MHz,
  input  logic                              reset_n,
  input  logic                              wr_en,
  input  logic [DBITS-1:0]                  wr_data,
  input  logic                              rd_en,
  output logic [DBITS-1:0]                  rd_data,
  output logic                              empty,
  output logic                              full,
`ifdef UART_RX_FIFO_OVERRUN_EN
  output logic                              overrun,
  input  logic                              clr_overrun,
`endif
  output logic [fifo_cnt_w(ADDR_BITS)-1:0]  count
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [ADDR_BITS-1:0] w_addr;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 wr_accept;

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [DBITS-1:0] mem_d [DEPTH];

  fifo_ctrl #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ctrl (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
`ifdef UART_RX_FIFO_OVERRUN_EN
    .clr_overrun (clr_overrun),
    .overrun     (overrun),
`endif
    .w_addr      (w_addr),
    .r_addr      (r_addr),
    .wr_accept   (wr_accept),
    .empty       (empty),
    .full        (full),
    .count       (count)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_accept) mem_d[w_addr] = wr_data;
  end

  // Storage is not reset: an empty queue never exposes stale contents.
  always_ff @(posedge clk_100MHz) begin
    mem_q <= mem_d;
  end

  assign rd_data = empty ? '0 : mem_q[r_addr];

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer of the UART system, directly downstream of the UART receiver. It captures each completed data word on the receiver's one-cycle `data_ready` strobe and holds it in a circular queue. Words are released to the consuming logic (UART top, display/ALU logic) through a show-ahead read port. This decouples the fixed serial arrival rate from a consumer that may stall for many character times.

## Interface
Parameters:
- DBITS, 8, data word width; must equal the receiver's DBITS
- ADDR_BITS, 4, log2 of depth; depth = 2**ADDR_BITS (default 16 words)

Ports:
- clk_100MHz  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- wr_en  input  1  write strobe, driven by receiver data_ready; one-cycle pulse per word
- wr_data  input  DBITS  word to store, receiver data_out
- rd_en  input  1  consumer pops the head word this cycle
- rd_data  output  DBITS  head word (show-ahead); 0 when empty
- empty  output  1  no words stored
- full  output  1  2**ADDR_BITS words stored
- count  output  ADDR_BITS+1  number of stored words, 0..2**ADDR_BITS
- overrun  output  1  sticky dropped-word flag (only with UART_RX_FIFO_OVERRUN_EN)
- clr_overrun  input  1  clears overrun (only with UART_RX_FIFO_OVERRUN_EN)

## Operation
- Storage: 2**ADDR_BITS x DBITS register array.
- Pointers: w_ptr and r_ptr, each ADDR_BITS bits, wrap modulo depth. Fullness is tracked by count, not by pointer comparison.
- Write accepted when wr_en=1 and (full=0 or rd_en=1). The word goes to mem[w_ptr] and w_ptr increments.
- Read accepted when rd_en=1 and empty=0. r_ptr increments.
- rd_en while empty: ignored, no pointer or count change.
- wr_en while full and rd_en=0: word dropped, no state change except overrun.
- Simultaneous accepted read and write: both pointers advance, count unchanged.
  - When full, this frees the slot that is written, so no drop occurs.
- Simultaneous rd_en and wr_en while empty: read ignored, write accepted, count 0->1.
- count: +1 on write only, -1 on read only, unchanged on both or neither. empty = (count==0). full = (count==2**ADDR_BITS).
- rd_data is combinational: mem[r_ptr] when empty=0, all-zero when empty=1.
- No state machine. Behaviour is fully defined by pointers and count.

## Timing
- Reset (reset_n low, asynchronous): w_ptr=0, r_ptr=0, count=0, empty=1, full=0, rd_data=0, overrun=0. Memory contents need not be cleared.
- Reset asserted mid-operation discards all stored words immediately, independent of clock.
- Write-to-read latency: a word written on edge N appears on rd_data and deasserts empty after edge N (same cycle as updated count).
- Pop: rd_data shows the word for the current cycle. After the rd_en edge, rd_data presents the next word, or 0 if the queue is now empty.
- Flags and count are registered-derived. They update on the same edge as the pointers, with no extra cycle.
- wr_en held high for multiple cycles writes one word per cycle. The receiver never does this, but it must be handled correctly.

## Configuration
- UART_RX_FIFO_OVERRUN_EN defined:
  - overrun output and clr_overrun input exist.
  - overrun sets on the edge where a write is dropped (wr_en=1, full=1, rd_en=0). It stays set until clr_overrun=1 or reset.
  - If set and clear happen in the same cycle, set wins.
- Not defined: both ports are absent and dropped words are silently discarded. All other behaviour is identical.

## Structure
- Shared package uart_pkg holds:
  - UART_DBITS (8) and UART_RX_FIFO_ADDR_BITS (4) defaults, shared with receiver and transmitter.
  - The count-width expression ADDR_BITS+1.
- Sub-module fifo_ctrl holds pointers, count and flag logic, and outputs w_addr, r_addr, wr_accept.
- The top holds the register array and the rd_data mux. fifo_ctrl is reused by the later transmit FIFO.

## Test plan
- Reset, then idle -> empty=1, full=0, count=0, rd_data=8'h00. rd_en=1 for 3 cycles -> no change.
- Write 8'hA5 then 8'h3C, then pop twice -> rd_data 8'hA5, then 8'h3C, then 8'h00. count 0->1->2->1->0.
- Write 16 words 8'h00..8'h0F -> full=1, count=16. 17th write 8'hFF is dropped and overrun=1 (macro on). Drain yields 8'h00..8'h0F in order. clr_overrun -> overrun=0.
- Full, then same-cycle wr_en (8'h77) and rd_en -> count stays 16, no overrun. After draining, the last word is 8'h77.
- Fill 10, pop 10, write 12 (pointer wrap) -> data order preserved across the wrap, count=12.
- Assert reset_n low asynchronously mid-clock with count=5 -> flags, count and rd_data return to reset values before the next edge.
